// File: rtl/xalu_ise_arb_if.sv
// Requester-side channel of the shared ISE arbiter: a valid/ready request
// carrying one ISE op, and a valid/ready response carrying its result.
interface xalu_ise_arb_if;
    logic        req_val;
    logic        req_rdy;
    logic [5:0]  fn;
    logic [6:0]  imm;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        rsp_val;
    logic        rsp_rdy;
    logic [31:0] rsp_out;
    logic        rsp_ok;

    modport master (
        output req_val, fn, imm, in1, in2, rsp_rdy,
        input  req_rdy, rsp_val, rsp_out, rsp_ok
    );

    modport slave (
        input  req_val, fn, imm, in1, in2, rsp_rdy,
        output req_rdy, rsp_val, rsp_out, rsp_ok
    );
endinterface

// File: rtl/xalu_ise_arb.sv
// Shares one xalu_ise datapath between two requesters: registers the winning
// request, drives the ISE for one cycle and holds each result until taken.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | no op outstanding; eligible for a grant
// ST_ISSUED | op sits in the shared issue register, ISE driven
// ST_RESP   | result held in the response register
module xalu_ise_arb #(
    parameter bit RR = 1'b1
) (
    input  logic          ise_clk,
    input  logic          ise_rst,
    xalu_ise_arb_if.slave r0,
    xalu_ise_arb_if.slave r1,
    output logic [5:0]    ise_fn,
    output logic [6:0]    ise_imm,
    output logic [31:0]   ise_in1,
    output logic [31:0]   ise_in2,
    output logic          ise_val,
    input  logic          ise_oval,
    input  logic [31:0]   ise_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_RESP   = 2'd2
    } st_t;

    st_t         st_q [2];
    st_t         st_d [2];
    logic [1:0]  rsp_rdy;
    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        accept;
    logic        last_q;

    logic        iv_q;
    logic        own_q;
    logic [5:0]  fn_q;
    logic [6:0]  imm_q;
    logic [31:0] in1_q;
    logic [31:0] in2_q;

    logic [31:0] rsp_out_q [2];
    logic        rsp_ok_q  [2];

    assign rsp_rdy = {r1.rsp_rdy, r0.rsp_rdy};
    assign elig[0] = r0.req_val && (st_q[0] == ST_IDLE);
    assign elig[1] = r1.req_val && (st_q[1] == ST_IDLE);
    assign accept  = |grant;

    // On a tie, round-robin favours whoever was not granted last.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = (RR && !last_q) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            st_d[k] = st_q[k];
            case (st_q[k])
                ST_IDLE:   if (grant[k])   st_d[k] = ST_ISSUED;
                ST_ISSUED:                 st_d[k] = ST_RESP;
                ST_RESP:   if (rsp_rdy[k]) st_d[k] = ST_IDLE;
                default:                   st_d[k] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            for (int k = 0; k < 2; k++) begin
                st_q[k] <= ST_IDLE;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            iv_q   <= 1'b0;
            own_q  <= 1'b0;
            fn_q   <= '0;
            imm_q  <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            last_q <= 1'b1;
        end else begin
            iv_q <= accept;
            if (accept) begin
                own_q  <= grant[1];
                last_q <= grant[1];
                fn_q   <= grant[1] ? r1.fn  : r0.fn;
                imm_q  <= grant[1] ? r1.imm : r0.imm;
                in1_q  <= grant[1] ? r1.in1 : r0.in1;
                in2_q  <= grant[1] ? r1.in2 : r0.in2;
            end
        end
    end

    // The ISE is combinational, so its result is captured on the issue edge.
    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            for (int k = 0; k < 2; k++) begin
                rsp_out_q[k] <= '0;
                rsp_ok_q[k]  <= 1'b0;
            end
        end else if (iv_q) begin
            rsp_out_q[own_q] <= ise_out;
            rsp_ok_q[own_q]  <= ise_oval;
        end
    end

    assign ise_val = iv_q;
    assign ise_fn  = iv_q ? fn_q  : '0;
    assign ise_imm = iv_q ? imm_q : '0;
    assign ise_in1 = iv_q ? in1_q : '0;
    assign ise_in2 = iv_q ? in2_q : '0;

    assign r0.req_rdy = grant[0];
    assign r0.rsp_val = (st_q[0] == ST_RESP);
    assign r0.rsp_out = rsp_out_q[0];
    assign r0.rsp_ok  = rsp_ok_q[0];

    assign r1.req_rdy = grant[1];
    assign r1.rsp_val = (st_q[1] == ST_RESP);
    assign r1.rsp_out = rsp_out_q[1];
    assign r1.rsp_ok  = rsp_ok_q[1];

endmodule

// File: tb/tb_xalu_ise_arb.sv
// Bench for xalu_ise_arb: a round-robin and a fixed-priority instance, each
// fed by a small behavioural stand-in for the combinational xalu_ise.
module tb_xalu_ise_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xalu_ise_arb_if a0 ();
    xalu_ise_arb_if a1 ();
    xalu_ise_arb_if b0 ();
    xalu_ise_arb_if b1 ();

    logic [5:0]  a_fn,  b_fn;
    logic [6:0]  a_imm, b_imm;
    logic [31:0] a_in1, a_in2, a_out, b_in1, b_in2, b_out;
    logic        a_val, a_oval, b_val, b_oval;

    // Stand-in ISE: supports fn[1:0]==0 with imm[6:5]==0, out = in1 + rotl(in2, imm[4:0]).
    function automatic logic [32:0] ise_ref(input logic [5:0] f, input logic [6:0] im,
                                            input logic [31:0] x, input logic [31:0] y);
        logic        ok;
        logic [31:0] r;
        ok = (f[1:0] == 2'b00) && (im[6:5] == 2'b00);
        r  = (y << im[4:0]) | (y >> (6'd32 - {1'b0, im[4:0]}));
        return {ok, ok ? (x + r) : 32'h0};
    endfunction

    assign {a_oval, a_out} = ise_ref(a_fn, a_imm, a_in1, a_in2);
    assign {b_oval, b_out} = ise_ref(b_fn, b_imm, b_in1, b_in2);

    xalu_ise_arb #(.RR(1'b1)) dut (
        .ise_clk(clk), .ise_rst(rst), .r0(a0), .r1(a1),
        .ise_fn(a_fn), .ise_imm(a_imm), .ise_in1(a_in1), .ise_in2(a_in2),
        .ise_val(a_val), .ise_oval(a_oval), .ise_out(a_out)
    );

    xalu_ise_arb #(.RR(1'b0)) dut_fp (
        .ise_clk(clk), .ise_rst(rst), .r0(b0), .r1(b1),
        .ise_fn(b_fn), .ise_imm(b_imm), .ise_in1(b_in1), .ise_in2(b_in2),
        .ise_val(b_val), .ise_oval(b_oval), .ise_out(b_out)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Round-robin run, cycle by cycle from the first tie: grants {r1,r0}, ise_val, rsp_val.
    logic [1:0] rr_gnt [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [5:0] rr_iv  = 6'b110110;
    logic [5:0] rr_rv0 = 6'b100100;
    logic [5:0] rr_rv1 = 6'b001000;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] e;
    int          issued = 0;
    int          cycles = 0;
    int          drain  = 0;
    bit          acc0   = 1'b0;
    bit          acc1   = 1'b0;

    initial begin
        a0.req_val = 0; a0.fn = 0; a0.imm = 0; a0.in1 = 0; a0.in2 = 0; a0.rsp_rdy = 0;
        a1.req_val = 0; a1.fn = 0; a1.imm = 0; a1.in1 = 0; a1.in2 = 0; a1.rsp_rdy = 0;
        b0.req_val = 0; b0.fn = 0; b0.imm = 0; b0.in1 = 0; b0.in2 = 0; b0.rsp_rdy = 0;
        b1.req_val = 0; b1.fn = 0; b1.imm = 0; b1.in1 = 0; b1.in2 = 0; b1.rsp_rdy = 0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_ise_val", 32'(a_val), 32'h0);
        chk("rst_ise_fn",  32'(a_fn),  32'h0);
        chk("rst_ise_imm", 32'(a_imm), 32'h0);
        chk("rst_ise_in1", a_in1,      32'h0);
        chk("rst_ise_in2", a_in2,      32'h0);
        chk("rst_r0_rsp_val", 32'(a0.rsp_val), 32'h0);
        chk("rst_r0_rsp_out", a0.rsp_out,      32'h0);
        chk("rst_r0_rsp_ok",  32'(a0.rsp_ok),  32'h0);
        chk("rst_r1_rsp_val", 32'(a1.rsp_val), 32'h0);
        chk("rst_r1_rsp_ok",  32'(a1.rsp_ok),  32'h0);
        chk("rst_req_rdy",    32'({a1.req_rdy, a0.req_rdy}), 32'h0);
        cyc();
        rst = 1'b0;

        // single supported op from r0
        cyc();
        a0.fn = 6'b000000; a0.imm = 7'b0000011; a0.in1 = 32'h12345678; a0.in2 = 32'h9ABCDEF0;
        a0.rsp_rdy = 1'b1; a0.req_val = 1'b1;
        smp();
        chk("single_gnt", 32'({a1.req_rdy, a0.req_rdy}), 32'h1);
        cyc();
        a0.req_val = 1'b0;
        smp();
        chk("single_iv_t1",  32'(a_val), 32'h1);
        chk("single_fn",     32'(a_fn),  32'h0);
        chk("single_imm",    32'(a_imm), 32'h3);
        chk("single_in1",    a_in1, 32'h12345678);
        chk("single_in2",    a_in2, 32'h9ABCDEF0);
        chk("single_rv_t1",  32'(a0.rsp_val), 32'h0);
        cyc();
        smp();
        chk("single_iv_t2",  32'(a_val), 32'h0);
        chk("single_rv_t2",  32'(a0.rsp_val), 32'h1);
        chk("single_out",    a0.rsp_out, 32'hE81B4DFC);
        chk("single_ok",     32'(a0.rsp_ok), 32'h1);
        cyc();
        smp();
        chk("single_rv_t3",  32'(a0.rsp_val), 32'h0);

        // unsupported op from r1
        cyc();
        a1.fn = 6'b000000; a1.imm = 7'b0100000; a1.in1 = 32'hDEADBEEF; a1.in2 = 32'h1;
        a1.rsp_rdy = 1'b1; a1.req_val = 1'b1;
        smp();
        chk("unsup_gnt", 32'({a1.req_rdy, a0.req_rdy}), 32'h2);
        cyc();
        a1.req_val = 1'b0;
        smp();
        chk("unsup_iv", 32'(a_val), 32'h1);
        cyc();
        smp();
        chk("unsup_rv",  32'(a1.rsp_val), 32'h1);
        chk("unsup_ok",  32'(a1.rsp_ok),  32'h0);
        chk("unsup_out", a1.rsp_out,      32'h0);
        cyc();
        smp();
        chk("unsup_rv_t3", 32'(a1.rsp_val), 32'h0);

        // both requesters stream continuously; last=1 so r0 takes the first tie
        cyc();
        a0.fn = 0; a0.imm = 7'd1; a0.in1 = 32'd1; a0.in2 = 32'd1; a0.req_val = 1'b1;
        a1.fn = 0; a1.imm = 7'd0; a1.in1 = 32'd5; a1.in2 = 32'd7; a1.req_val = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk($sformatf("rr_gnt_%0d", i), 32'({a1.req_rdy, a0.req_rdy}), 32'(rr_gnt[i]));
            chk($sformatf("rr_iv_%0d", i),  32'(a_val),      32'(rr_iv[i]));
            chk($sformatf("rr_rv0_%0d", i), 32'(a0.rsp_val), 32'(rr_rv0[i]));
            chk($sformatf("rr_rv1_%0d", i), 32'(a1.rsp_val), 32'(rr_rv1[i]));
            if (i == 2) chk("rr_out0", a0.rsp_out, 32'h3);
            if (i == 3) chk("rr_out1", a1.rsp_out, 32'hC);
            cyc();
        end
        a0.req_val = 1'b0; a1.req_val = 1'b0;
        repeat (4) cyc();

        // r0 alone (last=0), then a tie: RR grants r1, fixed priority grants r0
        b0.rsp_rdy = 1'b1; b1.rsp_rdy = 1'b1;
        a0.req_val = 1'b1; b0.req_val = 1'b1;
        smp();
        chk("tie_pre_a", 32'({a1.req_rdy, a0.req_rdy}), 32'h1);
        chk("tie_pre_b", 32'({b1.req_rdy, b0.req_rdy}), 32'h1);
        cyc();
        a0.req_val = 1'b0; b0.req_val = 1'b0;
        repeat (2) cyc();
        a0.req_val = 1'b1; a1.req_val = 1'b1; b0.req_val = 1'b1; b1.req_val = 1'b1;
        smp();
        chk("tie_rr", 32'({a1.req_rdy, a0.req_rdy}), 32'h2);
        chk("tie_fp", 32'({b1.req_rdy, b0.req_rdy}), 32'h1);
        cyc();
        a0.req_val = 1'b0; a1.req_val = 1'b0; b0.req_val = 1'b0; b1.req_val = 1'b0;
        repeat (4) cyc();

        // r0 holds its response for 10 cycles while r1 keeps being served
        a0.fn = 0; a0.imm = 7'd2; a0.in1 = 32'h100; a0.in2 = 32'd3;
        a0.rsp_rdy = 1'b0; a0.req_val = 1'b1;
        smp();
        chk("bp_gnt", 32'(a0.req_rdy), 32'h1);
        repeat (2) cyc();
        smp();
        chk("bp_rv_start", 32'(a0.rsp_val), 32'h1);
        for (int k = 0; k < 10; k++) begin
            cyc();
            a1.req_val = (k % 3 == 0);
            a1.fn = 0; a1.imm = 0; a1.in1 = 32'(k); a1.in2 = 32'd1;
            smp();
            chk("bp_r0_rv",  32'(a0.rsp_val), 32'h1);
            chk("bp_r0_out", a0.rsp_out,      32'h10C);
            chk("bp_r0_ok",  32'(a0.rsp_ok),  32'h1);
            chk("bp_r0_rdy", 32'(a0.req_rdy), 32'h0);
            if (k % 3 == 0) chk("bp_r1_gnt", 32'(a1.req_rdy), 32'h1);
            if (k % 3 == 2) begin
                chk("bp_r1_rv",  32'(a1.rsp_val), 32'h1);
                chk("bp_r1_out", a1.rsp_out,      32'(k - 1));
            end
        end
        cyc();
        a0.req_val = 1'b0; a1.req_val = 1'b0; a0.rsp_rdy = 1'b1;
        repeat (4) cyc();

        // reset while r0's op is on the ISE; last was 0 before reset
        a0.in1 = 32'h55; a0.req_val = 1'b1;
        smp();
        chk("mid_gnt", 32'(a0.req_rdy), 32'h1);
        cyc();
        a0.req_val = 1'b0;
        smp();
        chk("mid_iv", 32'(a_val), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_iv",  32'(a_val), 32'h0);
        chk("mid_rst_fn",  32'({a_fn, a_imm}), 32'h0);
        chk("mid_rst_in1", a_in1, 32'h0);
        chk("mid_rst_rv",  32'({a1.rsp_val, a0.rsp_val}), 32'h0);
        chk("mid_rst_out", a0.rsp_out, 32'h0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("mid_no_rsp", 32'(a0.rsp_val), 32'h0);
            cyc();
        end
        a0.req_val = 1'b1; a1.req_val = 1'b1;
        smp();
        chk("mid_first_tie", 32'({a1.req_rdy, a0.req_rdy}), 32'h1);
        cyc();
        a0.req_val = 1'b0; a1.req_val = 1'b0;
        repeat (4) cyc();

        // random soak against a per-requester in-order scoreboard
        while (drain < 8 && cycles < 80000) begin
            cyc();
            cycles++;
            if (issued >= 10000) begin
                drain++;
                a0.req_val = 1'b0; a1.req_val = 1'b0;
                a0.rsp_rdy = 1'b1; a1.rsp_rdy = 1'b1;
            end else begin
                if (acc0) a0.req_val = 1'b0;
                if (!a0.req_val && $urandom_range(3) != 0) begin
                    a0.fn = 6'($urandom()); a0.imm = 7'($urandom());
                    a0.in1 = $urandom(); a0.in2 = $urandom(); a0.req_val = 1'b1;
                end
                if (acc1) a1.req_val = 1'b0;
                if (!a1.req_val && $urandom_range(3) != 0) begin
                    a1.fn = 6'($urandom()); a1.imm = 7'($urandom());
                    a1.in1 = $urandom(); a1.in2 = $urandom(); a1.req_val = 1'b1;
                end
                a0.rsp_rdy = 1'($urandom_range(1));
                a1.rsp_rdy = 1'($urandom_range(1));
            end
            smp();
            chk("soak_rdy_excl", 32'(a0.req_rdy & a1.req_rdy), 32'h0);
            acc0 = a0.req_val && a0.req_rdy;
            acc1 = a1.req_val && a1.req_rdy;
            if (acc0) begin q0.push_back(ise_ref(a0.fn, a0.imm, a0.in1, a0.in2)); issued++; end
            if (acc1) begin q1.push_back(ise_ref(a1.fn, a1.imm, a1.in1, a1.in2)); issued++; end
            if (a0.rsp_val && a0.rsp_rdy) begin
                chk("soak_r0_pending", 32'(q0.size() != 0), 32'h1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("soak_r0_out", a0.rsp_out, e[31:0]);
                    chk("soak_r0_ok",  32'(a0.rsp_ok), 32'(e[32]));
                end
            end
            if (a1.rsp_val && a1.rsp_rdy) begin
                chk("soak_r1_pending", 32'(q1.size() != 0), 32'h1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("soak_r1_out", a1.rsp_out, e[31:0]);
                    chk("soak_r1_ok",  32'(a1.rsp_ok), 32'(e[32]));
                end
            end
        end
        chk("soak_issued",  32'(issued >= 10000), 32'h1);
        chk("soak_left_r0", 32'(q0.size()), 32'h0);
        chk("soak_left_r1", 32'(q1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
